// File: rtl/fx_chain_pkg.sv
// Shared types and constants for the effect-chain sequencer.
// No logic here; latency not applicable.
// No backpressure; constants only.
package fx_chain_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 12;

  // Dropped-sample counter width and its saturation value
  localparam int              OVR_W   = 8;
  localparam logic [OVR_W-1:0] OVR_MAX = 8'hFF;

  // Stage index is wide enough to hold 0..16; per-stage vectors are padded to
  // 2**IDX_W entries so the index never runs past a vector end.
  localparam int IDX_W = 5;
  localparam int PAD_N = 32;

endpackage

// File: rtl/fx_stage_timer.sv
// Per-stage wait timer: counts cycles spent waiting on one effect stage.
// Expired asserts combinationally once the count equals TIMEOUT.
// No backpressure; the counter holds at TIMEOUT until cleared.
module fx_stage_timer #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [CNT_W-1:0] r_count;

  assign o_expired = (r_count == CNT_W'(TIMEOUT));

  // Clear on stage launch, count while waiting, hold once expired
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fx_chain_sequencer.sv
// Carries one sample through STAGES effect modules via start/done, with bypass and timeout.
// Latency 2 + sum(enabled ? 1+d_i : 1) cycles from accept to sample_ready.
// Samples arriving while busy are dropped and counted; no stall is offered upstream.
module fx_chain_sequencer
  import fx_chain_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int STAGES  = 5,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    playback,
  input  logic                    new_sample_ready,
  input  logic [WIDTH-1:0]        samples_in,
  input  logic [STAGES-1:0]       stage_enable,
  output logic [STAGES-1:0]       stage_start,
  output logic [WIDTH-1:0]        stage_sample,
  input  logic [STAGES*WIDTH-1:0] stage_result,
  input  logic [STAGES-1:0]       stage_done,
  output logic [WIDTH-1:0]        to_ac97_data,
  output logic                    sample_ready,
  output logic                    busy,
  output logic [OVR_W-1:0]        overrun_count,
  output logic                    timeout_flag
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [WIDTH-1:0]  r_work;
  logic [WIDTH-1:0]  r_data;
  logic              r_sample_ready;
  logic              r_timeout;
  logic [OVR_W-1:0]  r_ovr;

  logic [PAD_N-1:0]             w_en_pad;
  logic [PAD_N-1:0]             w_done_pad;
  logic [PAD_N-1:0][WIDTH-1:0]  w_res_pad;
  logic [PAD_N-1:0]             w_start_pad;
  logic                         w_at_end;
  logic                         w_stage_en;
  logic                         w_stage_done;
  logic [WIDTH-1:0]             w_stage_res;
  logic                         w_launch;
  logic                         w_expired;
  logic                         w_overrun;

  // Widen per-stage inputs to the padded index range and pick the current stage
  always_comb begin
    w_en_pad    = '0;
    w_done_pad  = '0;
    w_res_pad   = '0;
    w_start_pad = '0;
    w_en_pad[STAGES-1:0]   = stage_enable;
    w_done_pad[STAGES-1:0] = stage_done;
    for (int i = 0; i < STAGES; i++) begin
      w_res_pad[i] = stage_result[i*WIDTH +: WIDTH];
    end
    if (w_launch) begin
      w_start_pad[r_idx] = 1'b1;
    end
  end

  assign w_at_end     = (r_idx == IDX_W'(STAGES));
  assign w_stage_en   = w_en_pad[r_idx];
  assign w_stage_done = w_done_pad[r_idx];
  assign w_stage_res  = w_res_pad[r_idx];
  // Start pulse is issued in the SELECT cycle itself so an enabled stage costs no extra cycle
  assign w_launch     = (r_state == ST_SELECT) && !w_at_end && w_stage_en;
  assign w_overrun    = playback && new_sample_ready && (r_state != ST_IDLE);

  fx_stage_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (w_launch),
    .i_enable  (r_state == ST_WAIT),
    .o_expired (w_expired)
  );

  // Chain control: accept a sample, walk the stages, then present the result
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_work         <= '0;
      r_data         <= '0;
      r_sample_ready <= 1'b0;
      r_timeout      <= 1'b0;
      r_ovr          <= '0;
    end else begin
      r_sample_ready <= 1'b0;
      if (w_overrun && (r_ovr != OVR_MAX)) begin
        r_ovr <= r_ovr + OVR_W'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (playback && new_sample_ready) begin
            r_work  <= samples_in;
            r_idx   <= '0;
            r_state <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (w_at_end) begin
            r_data         <= r_work;
            r_sample_ready <= 1'b1;
            r_state        <= ST_OUTPUT;
          end else if (w_stage_en) begin
            r_state <= ST_WAIT;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_WAIT: begin
          // A done arriving on the expiry cycle still delivers its result
          if (w_stage_done) begin
            r_work  <= w_stage_res;
            r_idx   <= r_idx + IDX_W'(1);
            r_state <= ST_SELECT;
          end else if (w_expired) begin
            r_timeout <= 1'b1;
            r_idx     <= r_idx + IDX_W'(1);
            r_state   <= ST_SELECT;
          end
        end
        ST_OUTPUT: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign stage_start   = w_start_pad[STAGES-1:0];
  assign stage_sample  = r_work;
  assign to_ac97_data  = r_data;
  assign sample_ready  = r_sample_ready;
  assign busy          = (r_state != ST_IDLE);
  assign overrun_count = r_ovr;
  assign timeout_flag  = r_timeout;

endmodule

// File: doc/fx_chain_sequencer.md
Name: fx_chain_sequencer

Overview:
Parametrised controller that carries one audio sample through a chain of STAGES effect modules using a start/done handshake. It replaces the fixed delay→chorus→compression→limiter→bitcrusher wiring. It adds per-stage bypass without latency through the stage, a per-stage timeout, overrun counting and a busy indication. It sits between the AC97 sample source and the AC97 output path; the effect modules attach to its stage bus.

Parameters:
WIDTH, 12, signed sample width in bits
STAGES, 5, number of effect stages, 1..16
TIMEOUT, 1023, maximum cycles in WAIT for one stage before that stage is skipped

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
playback  in  1  gates sample acceptance
new_sample_ready  in  1  one-cycle pulse, new sample available
samples_in  in  WIDTH  signed input sample
stage_enable  in  STAGES  bit i=1: stage i processes the sample; 0: stage i is bypassed
stage_start  out  STAGES  one-hot, one-cycle start pulse to stage i
stage_sample  out  WIDTH  working sample presented to the current stage
stage_result  in  STAGES*WIDTH  packed stage outputs; stage i occupies bits [i*WIDTH +: WIDTH]
stage_done  in  STAGES  one-cycle done pulse from stage i
to_ac97_data  out  WIDTH  processed sample, registered
sample_ready  out  1  one-cycle pulse; to_ac97_data is valid in that cycle
busy  out  1  high whenever state is not IDLE
overrun_count  out  8  count of dropped samples, saturates at 255
timeout_flag  out  1  sticky; set when any stage times out

Behaviour:
- Reset values: state IDLE, idx 0, working sample 0, stage_start 0, to_ac97_data 0, sample_ready 0, busy 0, overrun_count 0, timeout_flag 0.
- Reset during an operation aborts the chain. No sample_ready is issued. No stage_start is issued after reset.
- States:
  - IDLE: if playback && new_sample_ready, latch samples_in into the working register, set idx=0, go to SELECT.
  - SELECT: if idx==STAGES, go to OUTPUT. Otherwise read stage_enable[idx] in this cycle.
    - If 0: idx++ and stay in SELECT. The skip costs 1 cycle.
    - If 1: assert stage_start[idx] in this cycle, clear the timeout counter, go to WAIT.
  - WAIT: stage_done[idx] is accepted only in this state; done pulses in any other state are ignored.
    - On done: working register <= stage_result[idx], idx++, go to SELECT.
    - Otherwise, if the counter reaches TIMEOUT: keep the working register unchanged, set timeout_flag, idx++, go to SELECT.
    - Done and timeout in the same cycle: done wins.
    - Otherwise increment the counter.
  - OUTPUT: sample_ready=1 for this cycle only. to_ac97_data was loaded with the working register on entry to OUTPUT. Next state is IDLE.
- stage_sample always equals the working register. It is held stable from stage_start until done or timeout.
- Latency from the new_sample_ready cycle (cycle 0) to the sample_ready cycle is 2 + Σ(enabled ? 1+d_i : 1), where d_i ≥ 1 is the number of cycles from start to done.
- stage_enable is sampled per stage at its SELECT cycle. Changing it mid-chain affects only stages not yet reached.
- Overrun: playback && new_sample_ready while state is not IDLE (including OUTPUT) drops the sample and increments overrun_count, saturating at 255.
- playback low: new samples are ignored and not counted. A chain already in progress completes normally.
- Samples pass through unmodified; there is no arithmetic on them. Full signed range is preserved, including the minimum value.
- Timeout counter width is clog2(TIMEOUT+1).

Decomposition:
- Package fx_chain_pkg holds:
  - state encoding (IDLE, SELECT, WAIT, OUTPUT)
  - default WIDTH
  - overrun counter width (8) and saturation constant
- Sub-module fx_stage_timer: loadable counter with clear, enable and an expired output at TIMEOUT.

Test Plan (WIDTH=12, STAGES=3, TIMEOUT=15):
1. stage_enable=000, playback=1, samples_in=12'h123 pulsed → no stage_start; sample_ready at cycle 5; to_ac97_data=12'h123.
2. stage_enable=111; each stage returns input+1 with done 2 cycles after start; input 12'h100 → stage_start bits 0,1,2 pulse once each in order at cycles 1, 4, 7; sample_ready at cycle 11; to_ac97_data=12'h103.
3. stage_enable=111; stage 1 never asserts done; input 12'h010 → timeout_flag=1; stage 2 receives 12'h011; to_ac97_data=12'h012.
4. Second new_sample_ready during WAIT → overrun_count=1 and only one sample_ready. After 300 overruns → overrun_count=255.
5. playback=0 with pulses → no busy, no count. Reset asserted mid-WAIT → all outputs 0 and no sample_ready; the next sample processes normally.
6. Bypass chain with input 12'h800 → to_ac97_data=12'h800, sign preserved.
